// File: rtl/lane_transpose_pkg.sv
// Shared lane types for the NTT lane_transpose slice; no logic, no latency.
// The optional bypass port of lane_transpose is controlled by LANE_TRANSPOSE_BYPASS_EN.
`ifndef LANES
`define LANES 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package lane_transpose_pkg;

  localparam int LANES      = `LANES;
  localparam int DATA_WIDTH = `DATA_WIDTH;
  localparam int COL_W      = $clog2(LANES);

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef data_t [LANES-1:0]     lane_t;
  typedef lane_t [LANES-1:0]     xbank_t;

  typedef enum logic {
    R_IDLE   = 1'b0,
    R_STREAM = 1'b1
  } rd_state_t;

endpackage

// File: rtl/lane_transpose_if.sv
// Row-in / column-out bundle of lane_transpose; the bypass wire exists only with LANE_TRANSPOSE_BYPASS_EN.
// Master drives rows and out_stall/flush; slave returns columns and status.
interface lane_transpose_if;
  import lane_transpose_pkg::*;

  logic  valid_in;
  lane_t lane_in;
  logic  out_stall;
  logic  flush;
  lane_t lane_out;
  logic  valid_out;
  logic  block_done;
  logic  overflow;
`ifdef LANE_TRANSPOSE_BYPASS_EN
  logic  bypass;
`endif

  modport master (
`ifdef LANE_TRANSPOSE_BYPASS_EN
    output bypass,
`endif
    output valid_in, lane_in, out_stall, flush,
    input  lane_out, valid_out, block_done, overflow
  );

  modport slave (
`ifdef LANE_TRANSPOSE_BYPASS_EN
    input  bypass,
`endif
    input  valid_in, lane_in, out_stall, flush,
    output lane_out, valid_out, block_done, overflow
  );

endinterface

// File: rtl/lane_transpose_xpose_bank.sv
// One LANES x LANES register bank: row write on clk, combinational column read.
// No reset on storage; the owner tracks which rows are meaningful.
module xpose_bank
  import lane_transpose_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [COL_W-1:0] wr_row,
  input  lane_t            wr_dat,
  input  logic [COL_W-1:0] rd_col,
  output lane_t            rd_dat
);

  xbank_t mem;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_row] <= wr_dat;
    end
  end

  // Column read: output lane r is lane rd_col of stored row r.
  always_comb begin
    rd_dat = '0;
    for (int r = 0; r < LANES; r++) begin
      rd_dat[r] = mem[r][rd_col];
    end
  end

endmodule

// File: rtl/lane_transpose.sv
// 8x8 ping-pong transpose: first column word 2 cycles after the last row write; out_stall freezes the read side.
// Rows arriving while both banks are full are dropped (sticky overflow); LANE_TRANSPOSE_BYPASS_EN adds a bypass input.
module lane_transpose #(
  parameter int LANES = 8,
  parameter int DW    = `DATA_WIDTH
) (
  input logic             clk,
  input logic             rst_n,
  lane_transpose_if.slave io
);
  import lane_transpose_pkg::*;

  if (LANES != lane_transpose_pkg::LANES || DW != DATA_WIDTH) begin : g_cfg_err
    $error("lane_transpose: LANES/DW must match the lane_t definition");
  end

  localparam logic [COL_W-1:0] LAST = COL_W'(LANES - 1);

  rd_state_t        state, state_nxt;
  logic             wr_sel, rd_sel;
  logic [COL_W-1:0] wr_row, rd_col;
  logic [1:0]       full, full_nxt;
  logic             rd_fire, rd_last, wr_blocked, wr_ok, wr_last, bypass_eff;
  logic             we0, we1;
  lane_t            rd_dat0, rd_dat1, rd_dat;

  // Bypass only engages with no partial or pending block in flight.
`ifdef LANE_TRANSPOSE_BYPASS_EN
  assign bypass_eff = io.bypass && (state == R_IDLE) && (full == 2'b00) && (wr_row == '0);
`else
  assign bypass_eff = 1'b0;
`endif

  xpose_bank u_bank0 (
    .clk    (clk),
    .we     (we0),
    .wr_row (wr_row),
    .wr_dat (io.lane_in),
    .rd_col (rd_col),
    .rd_dat (rd_dat0)
  );

  xpose_bank u_bank1 (
    .clk    (clk),
    .we     (we1),
    .wr_row (wr_row),
    .wr_dat (io.lane_in),
    .rd_col (rd_col),
    .rd_dat (rd_dat1)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= R_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      R_IDLE:   if (full[rd_sel]) state_nxt = R_STREAM;
      R_STREAM: if (rd_last && !full[~rd_sel]) state_nxt = R_IDLE;
      default:  state_nxt = R_IDLE;
    endcase
    if (io.flush) begin
      state_nxt = R_IDLE;
    end
  end

  // FSM outputs and write-side decode
  always_comb begin
    rd_fire    = (state == R_STREAM) && !io.out_stall;
    rd_last    = rd_fire && (rd_col == LAST);
    // A bank freed by this cycle's last column read is writable at the same edge.
    wr_blocked = full[wr_sel] && !(rd_last && (rd_sel == wr_sel));
    wr_ok      = io.valid_in && !bypass_eff && !wr_blocked && !io.flush;
    wr_last    = wr_ok && (wr_row == LAST);
    we0        = wr_ok && !wr_sel;
    we1        = wr_ok && wr_sel;
    rd_dat     = rd_sel ? rd_dat1 : rd_dat0;
    full_nxt   = full;
    if (rd_last) full_nxt[rd_sel] = 1'b0;
    if (wr_last) full_nxt[wr_sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sel         <= 1'b0;
      rd_sel         <= 1'b0;
      wr_row         <= '0;
      rd_col         <= '0;
      full           <= 2'b00;
      io.lane_out    <= '0;
      io.valid_out   <= 1'b0;
      io.block_done  <= 1'b0;
      io.overflow    <= 1'b0;
    end else if (io.flush) begin
      wr_sel         <= 1'b0;
      rd_sel         <= 1'b0;
      wr_row         <= '0;
      rd_col         <= '0;
      full           <= 2'b00;
      io.valid_out   <= 1'b0;
      io.block_done  <= 1'b0;
      io.overflow    <= 1'b0;
    end else begin
      full <= full_nxt;
      if (wr_ok) begin
        wr_row <= wr_last ? '0 : wr_row + 1'b1;
        if (wr_last) wr_sel <= ~wr_sel;
      end
      if (io.valid_in && !bypass_eff && wr_blocked) begin
        io.overflow <= 1'b1;
      end
      if (rd_last) begin
        rd_col <= '0;
        rd_sel <= ~rd_sel;
      end else if (rd_fire) begin
        rd_col <= rd_col + 1'b1;
      end
      if (bypass_eff) begin
        io.lane_out   <= io.lane_in;
        io.valid_out  <= io.valid_in;
        io.block_done <= 1'b0;
      end else begin
        if (rd_fire) io.lane_out <= rd_dat;
        io.valid_out  <= rd_fire;
        io.block_done <= rd_last;
      end
    end
  end

endmodule

// File: tb/tb_lane_transpose.sv
// Directed bench for lane_transpose: single, back-to-back, gapped, stall/overflow, reset mid-block, bypass.
module tb_lane_transpose;
  import lane_transpose_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  lane_transpose_if u_if ();

  lane_transpose u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (u_if.slave)
  );

  task automatic chk(input string tag, input logic [$bits(lane_t)-1:0] obs,
                     input logic [$bits(lane_t)-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Input row g: lane c carries base + 8g + c.
  function automatic lane_t mk_row(input int base, input int g);
    lane_t w;
    for (int c = 0; c < LANES; c++) w[c] = data_t'(base + 8 * g + c);
    return w;
  endfunction

  // Column c of block b: lane r is lane c of row (8b + r).
  function automatic lane_t exp_col(input int base, input int b, input int c);
    lane_t w;
    for (int r = 0; r < LANES; r++) w[r] = data_t'(base + 8 * (8 * b + r) + c);
    return w;
  endfunction

  task automatic check_out(input string tag, input int base, input int b, input int c);
    if (b < 0) begin
      chk({tag, " idle valid_out"}, u_if.valid_out, 0);
      chk({tag, " idle block_done"}, u_if.block_done, 0);
    end else begin
      chk({tag, " valid_out"}, u_if.valid_out, 1);
      chk({tag, " lane_out"}, u_if.lane_out, exp_col(base, b, c));
      chk({tag, " block_done"}, u_if.block_done, (c == 7));
    end
  endtask

  // Rows every (gap+1) cycles; block b column c is due after edge (8b+7)(gap+1)+2+c.
  task automatic run_blocks(input string tag, input int nblk, input int gap, input int base);
    int ncyc;
    ncyc = (8 * (nblk - 1) + 7) * (gap + 1) + 13;
    for (int k = 0; k < ncyc; k++) begin
      int g;
      int ob;
      int oc;
      g  = k / (gap + 1);
      ob = -1;
      oc = 0;
      if ((k % (gap + 1)) == 0 && g < 8 * nblk) begin
        u_if.valid_in = 1'b1;
        u_if.lane_in  = mk_row(base, g);
      end else begin
        u_if.valid_in = 1'b0;
      end
      tick();
      for (int b = 0; b < nblk; b++) begin
        int c;
        c = k - ((8 * b + 7) * (gap + 1) + 2);
        if (c >= 0 && c < 8) begin
          ob = b;
          oc = c;
        end
      end
      check_out(tag, base, ob, oc);
    end
    u_if.valid_in = 1'b0;
    chk({tag, " overflow"}, u_if.overflow, 0);
  endtask

  initial begin
    rst_n          = 1'b0;
    u_if.valid_in  = 1'b0;
    u_if.lane_in   = '0;
    u_if.out_stall = 1'b0;
    u_if.flush     = 1'b0;
`ifdef LANE_TRANSPOSE_BYPASS_EN
    u_if.bypass    = 1'b0;
`endif
    #12;
    chk("reset lane_out", u_if.lane_out, 0);
    chk("reset valid_out", u_if.valid_out, 0);
    chk("reset block_done", u_if.block_done, 0);
    chk("reset overflow", u_if.overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_blocks("single", 1, 0, 0);
    run_blocks("b2b", 4, 0, 0);
    run_blocks("gap", 2, 2, 16'h100);

    // Stall with three blocks offered: third is dropped, first two survive.
    u_if.out_stall = 1'b1;
    for (int g = 0; g < 24; g++) begin
      u_if.valid_in = 1'b1;
      u_if.lane_in  = mk_row(16'h200, g);
      tick();
      check_out("stall_hold", 16'h200, -1, 0);
    end
    u_if.valid_in = 1'b0;
    tick();
    chk("stall overflow set", u_if.overflow, 1);
    u_if.out_stall = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      check_out("stall_drain", 16'h200, (k < 16) ? k / 8 : -1, k % 8);
    end
    chk("overflow sticky", u_if.overflow, 1);
    u_if.flush = 1'b1;
    tick();
    u_if.flush = 1'b0;
    chk("flush overflow", u_if.overflow, 0);
    chk("flush valid_out", u_if.valid_out, 0);
    tick();

    // Reset after five rows, then a fresh block must come out alone.
    for (int g = 0; g < 5; g++) begin
      u_if.valid_in = 1'b1;
      u_if.lane_in  = mk_row(16'h300, g);
      tick();
    end
    u_if.valid_in = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst lane_out", u_if.lane_out, 0);
    chk("midrst valid_out", u_if.valid_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_blocks("after_rst", 1, 0, 16'h400);

`ifdef LANE_TRANSPOSE_BYPASS_EN
    u_if.bypass   = 1'b1;
    u_if.valid_in = 1'b1;
    u_if.lane_in  = mk_row(0, 0);
    tick();
    chk("bypass lane_out", u_if.lane_out, mk_row(0, 0));
    chk("bypass valid_out", u_if.valid_out, 1);
    chk("bypass block_done", u_if.block_done, 0);
    u_if.valid_in = 1'b0;
    u_if.bypass   = 1'b0;
    tick();
    chk("bypass off valid_out", u_if.valid_out, 0);
    // bypass raised after row 3 is ignored until this block drains.
    for (int k = 0; k < 21; k++) begin
      u_if.valid_in = (k < 8);
      u_if.lane_in  = mk_row(16'h500, k);
      u_if.bypass   = (k >= 4);
      tick();
      check_out("bypass_mid", 16'h500, (k >= 9 && k < 17) ? 0 : -1, k - 9);
    end
    u_if.bypass   = 1'b0;
    u_if.valid_in = 1'b0;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/lane_transpose.md
Name: lane_transpose

Overview:
- 8x8 ping-pong transpose buffer for the NTT datapath. It sits directly downstream of the lane delay/deskew stage and consumes its lane_t words plus the valid strobe.
- Each block of 8 input words (rows) is re-emitted as 8 output words (columns): output word c, lane r = input word r, lane c.
- This gives the stride permutation needed between butterfly stages without memory round-trips.
- Two register banks allow a new block to be written while the previous block is read.

Parameters:
- LANES, 8, lanes per word and rows per block; must equal the lane_t width in lanes.
- DW, `DATA_WIDTH, bits per data_t element.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- valid_in  in  1  lane_in holds a valid row this cycle
- lane_in  in  lane_t  input row (LANES x data_t)
- out_stall  in  1  downstream hold; when 1, read side freezes
- flush  in  1  synchronous abort; discards both banks' contents and all counters
- lane_out  out  lane_t  transposed column word, registered
- valid_out  out  1  lane_out valid
- block_done  out  1  one-cycle pulse with the last (column LANES-1) output word
- overflow  out  1  sticky: a valid_in row was dropped; cleared by flush or reset

Behaviour:
- Reset (async, rst_n=0):
  - wr_sel=0, rd_sel=0, wr_row=0, rd_col=0, full[1:0]=0, read FSM in R_IDLE.
  - lane_out=0, valid_out=0, block_done=0, overflow=0.
  - Bank storage is not reset.
- Write side:
  - A valid_in row is written to bank[wr_sel] row wr_row, and wr_row increments.
  - On the write of row LANES-1: full[wr_sel] is set, wr_row wraps to 0, and wr_sel toggles.
  - If full[new wr_sel] is already 1 (both banks full), subsequent valid_in rows are dropped and overflow is set.
  - Writing resumes when that bank is freed.
- Read FSM:
  - R_IDLE -> R_STREAM when full[rd_sel]=1. The transition is evaluated every cycle, including the cycle after the fill edge.
  - R_STREAM, out_stall=0: register lane_out[r]=bank[rd_sel][r][rd_col] for all r, assert valid_out, and increment rd_col.
  - R_STREAM, out_stall=1: lane_out holds, valid_out=0, rd_col holds.
  - At rd_col=LANES-1 (unstalled): assert block_done with that word, clear full[rd_sel], toggle rd_sel, and reset rd_col to 0.
  - After that word: stay in R_STREAM if full[new rd_sel]=1 (back-to-back blocks, no bubble); otherwise go to R_IDLE.
- Latency: the first output word is valid 2 cycles after the edge that writes row LANES-1 (1 cycle to set full, 1 registered output).
- Throughput: 1 word/cycle sustained with out_stall=0. Overflow is impossible unless stalls accumulate.
- Simultaneous events:
  - If a read frees a bank in the same cycle a write would need it, the write is accepted (free takes effect before the full check).
  - flush has priority over valid_in and the read FSM. It clears counters, full, overflow, valid_out and block_done the next cycle; lane_out holds its value.
- Reset mid-block: all partial data is discarded; output is silent until a complete new block arrives.
- valid_in gaps (DATA_GAP) are tolerated; rows need not be consecutive cycles.

Optional Feature:
- Macro LANE_TRANSPOSE_BYPASS_EN.
- Defined:
  - Adds input port bypass (1 bit).
  - While bypass=1, wr_row=0 and both full flags=0, lane_in/valid_in are registered straight to lane_out/valid_out (1-cycle latency, no transpose), and block_done is held 0.
  - bypass asserted mid-block is ignored until the block boundary.
- Not defined: the port is absent and the block always transposes.

Decomposition:
- Shared package/defines.sv: data_t, lane_t, `LANES, `DATA_WIDTH (existing), plus a new typedef xbank_t (LANES x lane_t).
- Sub-module xpose_bank: one LANES x LANES register bank with row write (we, row index, lane_t) and column read (col index -> lane_t).
- Top instantiates two xpose_bank instances plus the control/FSM.

Test Plan:
- Single block: rows r=0..7, lane c = 8r+c, valid every cycle -> out word 0 = {0,8,16,...,56}, word 7 = {7,15,...,63}; valid_out 2 cycles after row 7; block_done on word 7.
- Back-to-back: 4 blocks of continuous valid_in (values 0..255) -> 32 contiguous valid_out cycles, no bubbles, each block correctly transposed, overflow=0.
- Gapped input: valid_in 1-of-3 (DATA_GAP=2) for 2 blocks -> identical transposed data, block_done twice.
- Stall/overflow: out_stall=1 held while 3 full blocks are sent -> third block dropped, overflow=1. Release the stall -> blocks 1 and 2 emitted intact. flush -> overflow=0.
- Reset mid-block: rst_n low after row 4, then a fresh full block -> only the new block is output, with no stale data.
- Bypass (macro on): bypass=1 in idle, lane_in = {0..7} -> lane_out = {0..7} one cycle later. Asserting bypass mid-block -> ignored until the block completes.
